// File: rtl/exc_redirect_ctrl_if.sv
// exc_redirect_ctrl_if: CP0 flush request, inst-SRAM handshake and redirect outputs around exc_redirect_ctrl.
interface exc_redirect_ctrl_if;
    logic        to_be_flushed;
    logic [31:0] new_pc;
    logic        inst_req;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        flush;
    logic        br_e;
    logic [31:0] br_addr;
    logic        resp_discard;
    logic        busy;
    modport master (
        output to_be_flushed, new_pc, inst_req, inst_addr_ok, inst_data_ok,
        input  flush, br_e, br_addr, resp_discard, busy
    );
    modport slave (
        input  to_be_flushed, new_pc, inst_req, inst_addr_ok, inst_data_ok,
        output flush, br_e, br_addr, resp_discard, busy
    );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: CP0 flush -> flush pulse, held fetch redirect and stale-response discard.
// Define FLUSH_BYPASS_EN for a zero-latency redirect driven straight from to_be_flushed/new_pc.
module exc_redirect_ctrl #(
    parameter int MAX_OUTST = 3
) (
    input logic clk,
    input logic rst,
    exc_redirect_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] outst, outst_nxt, disc, disc_nxt, disc_d;
    logic [31:0] tgt, tgt_d;
    logic acc;
    assign acc       = bus.inst_req & bus.inst_addr_ok;
    assign outst_nxt = outst + CW'(acc) - CW'(bus.inst_data_ok);
    assign disc_nxt  = disc - CW'(bus.inst_data_ok & (disc != '0));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            outst <= '0;
            disc  <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            outst <= outst_nxt;
            disc  <= disc_d;
            tgt   <= tgt_d;
        end
    end
    always_comb begin
        state_nxt = state;
        disc_d    = disc;
        tgt_d     = tgt;
        if (state != IDLE) disc_d = disc_nxt;
        if (state == REDIRECT && acc) state_nxt = (disc_nxt != '0) ? DRAIN : IDLE;
        if (state == DRAIN && disc_nxt == '0) state_nxt = IDLE;
        // The newest flush always wins and re-latches target and discard count.
        if (bus.to_be_flushed) begin
            tgt_d = bus.new_pc;
`ifdef FLUSH_BYPASS_EN
            disc_d    = acc ? outst - CW'(bus.inst_data_ok) : outst_nxt;
            state_nxt = acc ? ((disc_d != '0) ? DRAIN : IDLE) : REDIRECT;
`else
            disc_d    = outst_nxt;
            state_nxt = REDIRECT;
`endif
        end
    end
    assign bus.flush        = bus.to_be_flushed;
    assign bus.resp_discard = bus.inst_data_ok & (disc != '0) & (state != IDLE);
    assign bus.busy         = state != IDLE;
`ifdef FLUSH_BYPASS_EN
    assign bus.br_e    = bus.to_be_flushed | (state == REDIRECT);
    assign bus.br_addr = bus.br_e ? (bus.to_be_flushed ? bus.new_pc : tgt) : '0;
`else
    assign bus.br_e    = state == REDIRECT;
    assign bus.br_addr = bus.br_e ? tgt : '0;
`endif
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(outst == CW'(MAX_OUTST) && acc && !bus.inst_data_ok));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(outst == '0 && bus.inst_data_ok));
endmodule
